ysyx_201979054_axi_mem_slave: RTL and testbench

YSYX_201979054_AXI_MEM_SLAVE -- requirements
Module: ysyx_201979054_axi_mem_slave

---
 rtl/ysyx_201979054_axi_mem_slave.sv | 160 ++++++++++++++++
 tb/tb_ysyx_201979054_axi_mem_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_201979054_axi_mem_slave.sv
// AXI4 INCR-burst memory slave: 32-bit word memory, one outstanding read or write burst at a time.
// Optional macro YSYX_201979054_AXI_SLVERR_EN: out-of-range beats return SLVERR instead of aliasing.
module ysyx_201979054_axi_mem_slave #(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_ar_valid,
    output logic                  o_ar_ready,
    input  logic [ADDR_WIDTH-1:0] i_ar_addr,
    input  logic [7:0]            i_ar_len,
    output logic                  o_r_valid,
    input  logic                  i_r_ready,
    output logic [31:0]           o_r_data,
    output logic [1:0]            o_r_resp,
    output logic                  o_r_last,
    input  logic                  i_aw_valid,
    output logic                  o_aw_ready,
    input  logic [ADDR_WIDTH-1:0] i_aw_addr,
    input  logic [7:0]            i_aw_len,
    input  logic                  i_w_valid,
    output logic                  o_w_ready,
    input  logic [31:0]           i_w_data,
    input  logic [3:0]            i_w_strb,
    input  logic                  i_w_last,
    output logic                  o_b_valid,
    input  logic                  i_b_ready,
    output logic [1:0]            o_b_resp
);

    localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;
`ifdef YSYX_201979054_AXI_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [7:0]              len;
    logic [7:0]              cnt;
    logic [31:0]             r_data;
    logic                    r_err;
    logic                    b_err;
    logic                    ar_hs, aw_hs, r_hs, w_hs;
    logic [31:0]             mem [MEM_WORDS];

    function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[MEM_DEPTH_LOG2+1:2];
    endfunction

    // Any set bit above the word index means the beat falls outside the memory.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return SLVERR_EN && ((a >> (MEM_DEPTH_LOG2 + 2)) != '0);
    endfunction

    assign next_addr = addr + ADDR_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (arst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        o_ar_ready = 1'b0;
        o_aw_ready = 1'b0;
        o_r_valid  = 1'b0;
        o_w_ready  = 1'b0;
        o_b_valid  = 1'b0;
        ar_hs      = 1'b0;
        aw_hs      = 1'b0;
        r_hs       = 1'b0;
        w_hs       = 1'b0;
        case (state)
            IDLE: begin
                o_ar_ready = 1'b1;
                o_aw_ready = ~i_ar_valid;
                if (i_ar_valid) begin
                    ar_hs      = 1'b1;
                    state_next = READ;
                end else if (i_aw_valid) begin
                    aw_hs      = 1'b1;
                    state_next = WRITE;
                end
            end
            READ: begin
                o_r_valid = 1'b1;
                if (i_r_ready) begin
                    r_hs = 1'b1;
                    if (cnt == len) state_next = IDLE;
                end
            end
            WRITE: begin
                o_w_ready = 1'b1;
                if (i_w_valid) begin
                    w_hs = 1'b1;
                    if (i_w_last || cnt == len) state_next = WRESP;
                end
            end
            WRESP: begin
                o_b_valid = 1'b1;
                if (i_b_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data is prefetched into a register so the beat stays stable while stalled.
    always_ff @(posedge clk) begin
        if (arst) begin
            addr   <= '0;
            len    <= '0;
            cnt    <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
            b_err  <= 1'b0;
        end else if (ar_hs) begin
            addr   <= i_ar_addr;
            len    <= i_ar_len;
            cnt    <= '0;
            r_data <= out_of_range(i_ar_addr) ? 32'h0 : mem[word_idx(i_ar_addr)];
            r_err  <= out_of_range(i_ar_addr);
        end else if (aw_hs) begin
            addr  <= i_aw_addr;
            len   <= i_aw_len;
            cnt   <= '0;
            b_err <= 1'b0;
        end else if (r_hs) begin
            addr   <= next_addr;
            cnt    <= cnt + 8'd1;
            r_data <= out_of_range(next_addr) ? 32'h0 : mem[word_idx(next_addr)];
            r_err  <= out_of_range(next_addr);
        end else if (w_hs) begin
            addr  <= next_addr;
            cnt   <= cnt + 8'd1;
            b_err <= b_err | out_of_range(addr);
        end
    end

    // NOTE: the memory array has no reset; contents survive arst and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (!arst && w_hs && !out_of_range(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (i_w_strb[b]) mem[word_idx(addr)][8*b +: 8] <= i_w_data[8*b +: 8];
            end
        end
    end

    assign o_r_data = r_data;
    assign o_r_resp = r_err ? 2'b10 : 2'b00;
    assign o_r_last = (state == READ) && (cnt == len);
    assign o_b_resp = b_err ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_ysyx_201979054_axi_mem_slave.sv
// Directed self-checking bench for ysyx_201979054_axi_mem_slave (default parameters).
// Expectations follow YSYX_201979054_AXI_SLVERR_EN when the bench is built with it.
module tb_ysyx_201979054_axi_mem_slave;

    logic        clk = 1'b0;
    logic        arst;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] exp_r [16];
    logic [1:0]  oor_resp;
    logic [31:0] oor_data;

    always #5 clk = ~clk;

    ysyx_201979054_axi_mem_slave #(.MEM_DEPTH_LOG2(12), .ADDR_WIDTH(32)) dut (
        .clk(clk), .arst(arst),
        .i_ar_valid(ar_valid), .o_ar_ready(ar_ready), .i_ar_addr(ar_addr), .i_ar_len(ar_len),
        .o_r_valid(r_valid), .i_r_ready(r_ready), .o_r_data(r_data), .o_r_resp(r_resp), .o_r_last(r_last),
        .i_aw_valid(aw_valid), .o_aw_ready(aw_ready), .i_aw_addr(aw_addr), .i_aw_len(aw_len),
        .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data), .i_w_strb(w_strb), .i_w_last(w_last),
        .o_b_valid(b_valid), .i_b_ready(b_ready), .o_b_resp(b_resp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                            input int b_delay, input logic [1:0] bresp_exp);
        int n = 0;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len;
        #1;
        while (!aw_ready && n < 50) begin step(); n++; end
        check("aw_ready", aw_ready, 1);
        step();
        aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == nbeats - 1);
            #1;
            check("w_ready", w_ready, 1);
            step();
        end
        w_valid = 1'b0; w_last = 1'b0;
        for (int i = 0; i < b_delay; i++) begin
            #1;
            check("b_valid_held", b_valid, 1);
            check("b_resp_held", b_resp, bresp_exp);
            step();
        end
        b_ready = 1'b1;
        #1;
        check("b_valid", b_valid, 1);
        check("b_resp", b_resp, bresp_exp);
        step();
        b_ready = 1'b0;
        #1;
        check("b_valid_clear", b_valid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int stall_beat,
                           input logic [1:0] resp_exp);
        int n = 0;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len;
        #1;
        while (!ar_ready && n < 50) begin step(); n++; end
        check("ar_ready", ar_ready, 1);
        step();
        ar_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_beat) begin
                r_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("r_valid_stall", r_valid, 1);
                    check("r_data_stall", r_data, exp_r[i]);
                    check("r_last_stall", r_last, (i == int'(len)) ? 1 : 0);
                    step();
                end
            end
            r_ready = 1'b1;
            #1;
            check("r_valid", r_valid, 1);
            check("r_data", r_data, exp_r[i]);
            check("r_last", r_last, (i == int'(len)) ? 1 : 0);
            check("r_resp", r_resp, resp_exp);
            step();
        end
        r_ready = 1'b0;
        #1;
        check("r_valid_clear", r_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef YSYX_201979054_AXI_SLVERR_EN
        oor_resp = 2'b10;
`else
        oor_resp = 2'b00;
`endif
        arst = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; ar_len = '0; r_ready = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; aw_len = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
        repeat (3) step();
        arst = 1'b0;
        #1;
        check("rst_ar_ready", ar_ready, 1);
        check("rst_aw_ready", aw_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_r_resp", r_resp, 0);
        check("rst_b_resp", b_resp, 0);

        // Four-beat write then read back at 0x100.
        wd[0] = 32'hA0A0A0A0; wd[1] = 32'hA1A1A1A1; wd[2] = 32'hA2A2A2A2; wd[3] = 32'hA3A3A3A3;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(32'h100, 8'd3, 4, 0, 2'b00);
        for (int i = 0; i < 4; i++) exp_r[i] = wd[i];
        do_read(32'h100, 8'd3, -1, 2'b00);

        // Partial strobe merge at 0x40.
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(32'h40, 8'd0, 1, 0, 2'b00);
        wd[0] = 32'h12345678; ws[0] = 4'b0011;
        do_write(32'h40, 8'd0, 1, 0, 2'b00);
        exp_r[0] = 32'hFFFF5678;
        do_read(32'h40, 8'd0, -1, 2'b00);

        // AR and AW together: read wins, write waits for the read burst.
        ar_valid = 1'b1; ar_addr = 32'h100; ar_len = 8'd3;
        aw_valid = 1'b1; aw_addr = 32'h200; aw_len = 8'd0;
        #1;
        check("both_ar_ready", ar_ready, 1);
        check("both_aw_ready", aw_ready, 0);
        step();
        ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_r[i] = {4{8'hA0 + 8'(i)}};
        for (int i = 0; i < 4; i++) begin
            r_ready = 1'b1;
            #1;
            check("both_aw_held", aw_ready, 0);
            check("both_r_data", r_data, exp_r[i]);
            step();
        end
        r_ready = 1'b0;
        #1;
        check("both_aw_ready_after", aw_ready, 1);
        step();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 32'h55AA55AA; w_strb = 4'hF; w_last = 1'b1;
        #1;
        check("both_w_ready", w_ready, 1);
        step();
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        #1;
        check("both_b_valid", b_valid, 1);
        step();
        b_ready = 1'b0;
        exp_r[0] = 32'h55AA55AA;
        do_read(32'h200, 8'd0, -1, 2'b00);

        // Read stall mid-burst and delayed write response.
        for (int i = 0; i < 4; i++) exp_r[i] = {4{8'hA0 + 8'(i)}};
        do_read(32'h100, 8'd3, 2, 2'b00);
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        do_write(32'h80, 8'd0, 1, 3, 2'b00);

        // Early w_last: len 3 burst terminated after two beats.
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h500, 8'd3, 2, 0, 2'b00);
        exp_r[0] = 32'h11111111; exp_r[1] = 32'h22222222;
        do_read(32'h500, 8'd1, -1, 2'b00);

        // Upper address bits: SLVERR when enabled, aliasing to word 0 otherwise.
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(32'h0, 8'd0, 1, 0, 2'b00);
`ifdef YSYX_201979054_AXI_SLVERR_EN
        oor_data = 32'h0;
`else
        oor_data = 32'hCAFEF00D;
`endif
        exp_r[0] = oor_data;
        do_read(32'h00010000, 8'd0, -1, oor_resp);
        wd[0] = 32'hDEADBEEF;
        do_write(32'h00010000, 8'd0, 1, 0, oor_resp);
        exp_r[0] = (oor_resp == 2'b10) ? 32'hCAFEF00D : 32'hDEADBEEF;
        do_read(32'h0, 8'd0, -1, 2'b00);

        // Reset during beat 2 of an 8-beat read, then a clean re-read.
        for (int i = 0; i < 8; i++) begin
            wd[i] = 32'h30000000 + 32'(i);
            ws[i] = 4'hF;
            exp_r[i] = wd[i];
        end
        do_write(32'h300, 8'd7, 8, 0, 2'b00);
        ar_valid = 1'b1; ar_addr = 32'h300; ar_len = 8'd7;
        step();
        ar_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_ready = 1'b1;
            #1;
            check("rst_burst_data", r_data, exp_r[i]);
            step();
        end
        r_ready = 1'b0;
        #1;
        check("rst_beat2_data", r_data, exp_r[2]);
        arst = 1'b1;
        step();
        arst = 1'b0;
        #1;
        check("rst_mid_r_valid", r_valid, 0);
        check("rst_mid_ar_ready", ar_ready, 1);
        check("rst_mid_r_last", r_last, 0);
        do_read(32'h300, 8'd7, -1, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
